// File: rtl/qfix_pkg.sv
// Shared Q16.16 fixed-point constants and the gate-apply FSM state type.
package qfix_pkg;
    localparam int W    = 32;
    localparam int FRAC = 16;

    localparam logic signed [W-1:0] Q_ONE       = 32'sh0001_0000;
    localparam logic signed [W-1:0] Q_MAX       = 32'sh7FFF_FFFF;
    localparam logic signed [W-1:0] Q_MIN       = 32'sh8000_0000;
    localparam logic signed [W-1:0] Q_INV_SQRT2 = 32'sd46341;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/fixed_point_add.sv
// Combinational saturating W-bit signed add.
module fixed_point_add
    import qfix_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);
    logic signed [W:0] sum;

    always_comb begin
        sum = {a[W-1], a} + {b[W-1], b};
        ovf = sum[W] ^ sum[W-1];
        if (ovf) begin
            y = sum[W] ? Q_MIN : Q_MAX;
        end else begin
            y = sum[W-1:0];
        end
    end
endmodule

// File: rtl/fixed_point_mult.sv
// Combinational Q16.16 multiply: full product, arithmetic shift by FRAC, saturate to W bits.
module fixed_point_mult
    import qfix_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);
    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] shr;

    always_comb begin
        prod = (2*W)'(a) * (2*W)'(b);
        shr  = prod >>> FRAC;
        // Result fits only when every bit above the W-bit sign agrees with it.
        ovf  = !((&shr[2*W-1:W-1]) || !(|shr[2*W-1:W-1]));
        if (ovf) begin
            y = shr[2*W-1] ? Q_MIN : Q_MAX;
        end else begin
            y = shr[W-1:0];
        end
    end
endmodule

// File: rtl/qgate_2x2_apply.sv
// Applies a 2x2 complex Q16.16 gate to one amplitude pair using one shared
// multiplier and one saturating adder, one product per cycle over 16 steps.
module qgate_2x2_apply
    import qfix_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] u00_re,
    input  logic [W-1:0] u00_im,
    input  logic [W-1:0] u01_re,
    input  logic [W-1:0] u01_im,
    input  logic [W-1:0] u10_re,
    input  logic [W-1:0] u10_im,
    input  logic [W-1:0] u11_re,
    input  logic [W-1:0] u11_im,
    input  logic [W-1:0] a0_re,
    input  logic [W-1:0] a0_im,
    input  logic [W-1:0] a1_re,
    input  logic [W-1:0] a1_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] b0_re,
    output logic [W-1:0] b0_im,
    output logic [W-1:0] b1_re,
    output logic [W-1:0] b1_im,
    output logic         overflow
);
    state_e              state_q, state_d;
    logic [3:0]          step_q, step_d;
    logic signed [W-1:0] acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic signed [W-1:0] b_q [4];
    logic signed [W-1:0] b_d [4];
    logic signed [W-1:0] u_q [8];
    logic signed [W-1:0] u_d [8];
    logic signed [W-1:0] a_q [4];
    logic signed [W-1:0] a_d [4];

    logic                k, c, j, p;
    logic signed [W-1:0] mul_a, mul_b, mul_y, term, sum;
    logic                mul_ovf, neg_ovf, add_ovf;

    function automatic logic [W:0] sat_neg(input logic signed [W-1:0] x);
        if (x == Q_MIN) begin
            return {1'b1, Q_MAX};
        end
        return {1'b0, -x};
    endfunction

    // step = {k, c, j, p}: output row, re/im, term index, product within term
    assign {k, c, j, p} = step_q;
    assign mul_a = u_q[{k, j, p}];
    assign mul_b = a_q[{j, c ^ p}];

    fixed_point_mult u_mult (
        .a   (mul_a),
        .b   (mul_b),
        .y   (mul_y),
        .ovf (mul_ovf)
    );

    // Only the second product of a real component is subtracted.
    always_comb begin
        term    = mul_y;
        neg_ovf = 1'b0;
        if (!c && p) begin
            {neg_ovf, term} = sat_neg(mul_y);
        end
    end

    fixed_point_add u_add (
        .a   (acc_q),
        .b   (term),
        .y   (sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        b_d         = b_q;
        u_d         = u_q;
        a_d         = a_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    u_d         = '{$signed(u00_re), $signed(u00_im), $signed(u01_re), $signed(u01_im),
                                    $signed(u10_re), $signed(u10_im), $signed(u11_re), $signed(u11_im)};
                    a_d         = '{$signed(a0_re), $signed(a0_im), $signed(a1_re), $signed(a1_im)};
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    step_d      = 4'd0;
                    in_ready_d  = 1'b0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                ovf_d  = ovf_q | mul_ovf | neg_ovf | add_ovf;
                step_d = step_q + 4'd1;
                if (j && p) begin
                    b_d[{k, c}] = sum;
                    acc_d       = '0;
                end else begin
                    acc_d       = sum;
                end
                if (step_q == 4'd15) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 4'd0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            b_q         <= '{default: '0};
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
        end
    end

    // Operand holding registers carry no reset; they are loaded before use.
    always_ff @(posedge clk) begin
        u_q <= u_d;
        a_q <= a_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign b0_re     = b_q[0];
    assign b0_im     = b_q[1];
    assign b1_re     = b_q[2];
    assign b1_im     = b_q[3];
endmodule

// File: tb/tb_qgate_2x2_apply.sv
// Randomized and directed bench for qgate_2x2_apply against a nested-loop complex-arithmetic model.
module tb_qgate_2x2_apply;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, overflow;
    logic [31:0] b0_re, b0_im, b1_re, b1_im;
    logic signed [31:0] tu [8];
    logic signed [31:0] ta [4];
    logic signed [31:0] eb [4];
    logic        eovf;
    bit          mf;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    qgate_2x2_apply dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u00_re    (tu[0]),
        .u00_im    (tu[1]),
        .u01_re    (tu[2]),
        .u01_im    (tu[3]),
        .u10_re    (tu[4]),
        .u10_im    (tu[5]),
        .u11_re    (tu[6]),
        .u11_im    (tu[7]),
        .a0_re     (ta[0]),
        .a0_im     (ta[1]),
        .a1_re     (ta[2]),
        .a1_im     (ta[3]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b0_re     (b0_re),
        .b0_im     (b0_im),
        .b1_re     (b1_re),
        .b1_im     (b1_im),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint satq(input longint v);
        if (v > 64'sd2147483647) begin
            mf = 1'b1;
            return 64'sd2147483647;
        end
        if (v < -64'sd2147483648) begin
            mf = 1'b1;
            return -64'sd2147483648;
        end
        return v;
    endfunction

    // b_k = sum_j U_kj * a_j, complex, each real product truncated and saturated, accumulation saturating in order.
    task automatic model();
        longint acc, t0, t1, ure, uim, are, aim;
        mf = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                acc = 0;
                for (int j = 0; j < 2; j++) begin
                    ure = longint'(tu[(2*k+j)*2]);
                    uim = longint'(tu[(2*k+j)*2+1]);
                    are = longint'(ta[2*j]);
                    aim = longint'(ta[2*j+1]);
                    t0 = satq((ure * ((c == 0) ? are : aim)) >>> 16);
                    t1 = satq((uim * ((c == 0) ? aim : are)) >>> 16);
                    if (c == 0) t1 = satq(-t1);
                    acc = satq(acc + t0);
                    acc = satq(acc + t1);
                end
                eb[2*k+c] = acc[31:0];
            end
        end
        eovf = mf;
    endtask

    task automatic set_ops(input logic [31:0] u0r, u0i, u1r, u1i, u2r, u2i, u3r, u3i,
                           input logic [31:0] x0r, x0i, x1r, x1i);
        tu = '{u0r, u0i, u1r, u1i, u2r, u2i, u3r, u3i};
        ta = '{x0r, x0i, x1r, x1i};
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 8; i++) tu[i] = rand_word();
        for (int i = 0; i < 4; i++) ta[i] = rand_word();
    endtask

    function automatic logic [31:0] rand_word();
        logic signed [31:0] v;
        v = $signed($urandom);
        case ($urandom_range(0, 3))
            0:       return v >>> 13;
            1:       return v;
            2:       return ($urandom_range(0, 1) != 0) ? 32'h0001_0000 : 32'hFFFF_0000;
            default: return v >>> 6;
        endcase
    endfunction

    task automatic start_txn(input string tag);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, n, 32'd16);
    endtask

    task automatic finish_txn(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] e0, e1, e2, e3, input logic eo);
        chk({tag, "_b0_re"}, b0_re, e0);
        chk({tag, "_b0_im"}, b0_im, e1);
        chk({tag, "_b1_re"}, b1_re, e2);
        chk({tag, "_b1_im"}, b1_im, e3);
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    task automatic hadamard(input logic [31:0] x0, input logic [31:0] x1);
        set_ops(32'd46341, 0, 32'd46341, 0, 32'd46341, 0, -32'sd46341, 0, x0, 0, x1, 0);
    endtask

    initial begin
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        expect_out("rst", 0, 0, 0, 0, 1'b0);

        hadamard(32'd65536, 0);
        start_txn("h0"); wait_done("h0");
        expect_out("h0", 32'd46341, 0, 32'd46341, 0, 1'b0);
        finish_txn("h0");

        hadamard(0, 32'd65536);
        start_txn("h1"); wait_done("h1");
        expect_out("h1", 32'd46341, 0, -32'sd46341, 0, 1'b0);
        finish_txn("h1");

        set_ops(0, 0, 0, 32'hFFFF_0000, 0, 32'h0001_0000, 0, 0, 32'd32768, 0, 0, 0);
        start_txn("py"); wait_done("py");
        expect_out("py", 0, 0, 0, 32'd32768, 1'b0);
        finish_txn("py");

        set_ops(32'h0001_0000, 0, 32'h0001_0000, 0, 0, 0, 0, 0, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 0);
        start_txn("sat"); wait_done("sat");
        expect_out("sat", 32'h7FFF_FFFF, 0, 0, 0, 1'b1);
        finish_txn("sat");

        hadamard(32'd65536, 0);
        start_txn("clean"); wait_done("clean");
        expect_out("clean", 32'd46341, 0, 32'd46341, 0, 1'b0);

        // Hold results under back-pressure while new operands are offered.
        rand_ops();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_b0_re", b0_re, 32'd46341);
            chk("bp_b1_re", b1_re, 32'd46341);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_release_vld", {31'd0, out_valid}, 32'd0);
        chk("bp_release_rdy", {31'd0, in_ready}, 32'd1);
        chk("bp_b0_kept", b0_re, 32'd46341);

        hadamard(32'd65536, 0);
        start_txn("abort");
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        expect_out("abort", 0, 0, 0, 0, 1'b0);

        hadamard(0, 32'd65536);
        start_txn("fresh"); wait_done("fresh");
        expect_out("fresh", 32'd46341, 0, -32'sd46341, 0, 1'b0);
        finish_txn("fresh");

        for (int t = 0; t < 30; t++) begin
            rand_ops();
            model();
            start_txn("rnd");
            rand_ops();
            wait_done("rnd");
            expect_out("rnd", eb[0], eb[1], eb[2], eb[3], eovf);
            finish_txn("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qgate_2x2_apply.md
Name: qgate_2x2_apply

Overview:
Sequential downstream consumer of fixed_point_mult and fixed_point_add. Applies one single-qubit gate, a 2x2 complex matrix U in Q16.16, to one amplitude pair (a0, a1), producing b0 = U00*a0 + U01*a1 and b1 = U10*a0 + U11*a1. Time-multiplexes one real multiplier and one saturating adder over 16 cycles per transaction. Sits between the gate-matrix/state-vector fetch logic and the state-vector write-back.

Parameters:
W, 32, total word width (signed Q16.16)
FRAC, 16, fractional bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operands valid
in_ready  out  1  block can accept a transaction
u00_re, u00_im, u01_re, u01_im, u10_re, u10_im, u11_re, u11_im  in  W each  gate matrix entries, signed Q16.16
a0_re, a0_im, a1_re, a1_im  in  W each  input amplitudes, signed Q16.16
out_valid  out  1  results valid
out_ready  in  1  consumer accepts results
b0_re, b0_im, b1_re, b1_im  out  W each  output amplitudes, signed Q16.16
overflow  out  1  sticky: any saturation occurred during this transaction

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high. On a rst edge: state IDLE, step=0, accumulator=0, b*=0, overflow=0, out_valid=0. in_ready is 1 in the cycle after reset.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, all 12 operands are latched into internal registers, accumulator=0, overflow=0, step=0 -> CALC. Operands are not sampled at any other time.
- CALC: in_ready=0, out_valid=0. Each edge performs one product and one accumulate; step is a 4-bit counter 0..15.
- Step decode: step = {k, c, j, p}, MSB first. k selects output b0/b1; c selects re/im; j selects term j (Ukj, aj); p selects product.
- re component: p=0 is Ukj.re*aj.re (added); p=1 is Ukj.im*aj.im (subtracted).
- im component: p=0 is Ukj.re*aj.im (added); p=1 is Ukj.im*aj.re (added).
- Product: full 64-bit signed product, arithmetic shift right by FRAC (truncation toward minus infinity), saturated to [0x80000000, 0x7FFFFFFF].
- Subtraction: the product is negated with saturation; -0x80000000 becomes 0x7FFFFFFF and sets overflow.
- Accumulate: saturating W-bit add, in the step order above. Intermediate saturation is not undone by later terms.
- overflow |= any product, negation or add saturation in this transaction.
- When p=1 and j=1 (steps 3, 7, 11, 15): the saturated sum is written to the selected b register, then the accumulator clears to 0.
- After the step-15 edge: -> DONE.
- DONE: out_valid=1; b* and overflow stable and held. On an edge with out_ready=1 -> IDLE, out_valid=0 next cycle. b*/overflow keep their values until the next transaction's step writes.
- Latency: accept at edge E0; out_valid high after edge E16 (16 cycles). Throughput is one transaction per 18 cycles with out_ready tied high.
- No overlap: in_valid is ignored outside IDLE.
- rst in CALC or DONE aborts the transaction immediately, with no partial output.

Decomposition:
- Package qfix_pkg: W, FRAC, Q_ONE=0x00010000, Q_MAX=0x7FFFFFFF, Q_MIN=0x80000000, Q_INV_SQRT2=46341; state enum (IDLE, CALC, DONE).
- Reuse the existing combinational fixed_point_mult and fixed_point_add as the single multiplier/adder instances; their overflow outputs feed the sticky flag.
- No further sub-module; the operand select mux and the FSM stay in qgate_2x2_apply.

Test Plan:
- Hadamard on |0>: U00=U01=U10=46341, U11=-46341 (all im=0); a0=65536, a1=0 -> b0_re=46341, b1_re=46341, im=0, overflow=0, out_valid exactly 16 cycles after accept.
- Hadamard on |1>: same U; a0=0, a1=65536 -> b0_re=46341, b1_re=-46341, overflow=0.
- Pauli-Y: U01=-i (im=-65536), U10=+i (im=65536); a0=32768, a1=0 -> b0=0, b1_im=32768, b1_re=0.
- Saturation: U00=U01=65536, a0_re=a1_re=0x7FFFFFFF -> b0_re=0x7FFFFFFF, overflow=1. A following clean Hadamard transaction reports overflow=0.
- Back-pressure: out_ready low for 5 cycles in DONE -> out_valid and b* held constant, in_ready=0, new in_valid ignored; accepted on the first out_ready=1 edge.
- Reset mid-op: assert rst at step 8 -> next cycle out_valid=0, in_ready=1, b*=0, overflow=0. A fresh transaction then completes correctly.
